video_mixer: RTL and testbench
==============================

# video_mixer

Parametrised layer compositor between the VGA timing generator and the DAC pins. It takes the raw timing (HB, VB, HS_, VS_) and one dot per layer from up to 16 layer sources (text terminal, bitmap, sprites), each with a programmable 12-bit-style RGB colour. It combines the layers by a frame-latched mode (priority, saturating additive, OR), blanks outside the visible area, and re-aligns sync with the pixel data. It replaces the hard-wired OR/mask mixing and the separate sync Delay instance at the top level.

## Interface
- Layers, 2: number of layer dot inputs, 1..16.
- W, 4: bits per colour channel.
- SrcDelay, 2: cycles from timing at the inputs to the matching DOT arriving, 0..15.
- CLK  in  1  pixel clock; all state on rising edge.
- RST_  in  1  asynchronous, active-low reset.
- HB, VB  in  1 each  horizontal/vertical blanking, active-high, from the timing generator.
- HS_, VS_  in  1 each  syncs, active-low.
- DOT  in  Layers  layer dots; bit i = layer i; valid SrcDelay cycles after the matching timing.
- MODE  in  2  mix mode request; 0 priority, 1 additive, 2 OR, 3 treated as 0.
- MASK  in  Layers  layer enable request.
- WE  in  1  colour register write strobe.
- WADDR  in  4  layer index for the write.
- WDATA  in  3*W  colour {R,G,B}, R in the MSBs.
- R, G, B  out  W each  pixel channels.
- HS_O_, VS_O_  out  1 each  delayed syncs, active-low.
- FRAME  out  1  one-cycle pulse when MODE/MASK are latched.

## Operation
- Colour registers COL[0..Layers-1], 3*W bits each. Reset value: all ones. If WE=1 and WADDR<Layers, COL[WADDR]<=WDATA at the clock edge; WADDR>=Layers is ignored. The new value is used by the pixel sampled on the next cycle, with no frame latching.
- Active mode/mask registers. Reset: mode=0, mask=all ones. Latched from MODE/MASK only on the cycle the input VB goes 0->1, using an internal VB history register with reset 0. FRAME pulses on that same edge.
- Timing delay line, SrcDelay+2 stages of {HB,VB,HS_,VS_}. Reset stage values: HB=1, VB=1, HS_=1, VS_=1.
- Stage 1 registers eff = DOT & mask, using the delayed active mode/mask. The latch point is the input VB edge, so the new mode applies from the first pixel after that edge reaches stage 1.
- Stage 2 computes the pixel and blanks it. If delayed HB|VB, the output is 0.
- Mode 0, priority: colour of the lowest-index set bit of eff; 0 if eff=0.
- Mode 1, additive: per-channel sum of COL[i] over set bits, with width W+4. Saturate to 2^W-1.
- Mode 2, OR: bitwise OR of COL[i] over set bits.
- Mode 3 behaves exactly as mode 0.
- A colour write during visible area affects only pixels sampled after it. No tearing protection for colours.

## Timing
- Timing input at cycle t pairs with DOT at t+SrcDelay. R/G/B and HS_O_/VS_O_ for that pixel appear at t+SrcDelay+2. Syncs and pixels are always mutually aligned.
- Throughput: one pixel per clock, no stalls.
- Reset values: R=G=B=0, HS_O_=VS_O_=1, FRAME=0, and all pipeline registers cleared. This holds immediately on RST_ low, without waiting for a clock.
- Reset released mid-line: outputs stay blanked until the delay line refills, SrcDelay+2 cycles. No spurious sync pulse is emitted.
- WE coincident with a VB rise: both the colour write and the mode/mask latch happen on that edge.
- SrcDelay=0 is legal. Latency is then 2.

## Test plan
- Reset: hold RST_=0 mid-frame, without a clock edge -> R/G/B=0 and HS_O_=VS_O_=1 immediately. After release, first non-blank output is no earlier than SrcDelay+2 cycles.
- Latency, Layers=2, W=4, SrcDelay=2, mode 0. Pulse HS_ low at cycle 10 -> HS_O_ low at cycle 14. DOT=2'b01 at cycle 12 in visible area -> RGB=F,F,F at cycle 14.
- Priority/OR/additive, with COL0=0x800 and COL1=0x0A0. Mode 0, DOT=11 -> R=8, G=0, B=0. Latch mode 2 at VB rise, DOT=11 -> R=8, G=A, B=0. Set COL1=0x9A0 and latch mode 1 -> R=F (saturated), G=A.
- Frame latching: change MODE mid-frame -> output unchanged until VB 0->1. FRAME pulses exactly one cycle there, and the new mode applies afterwards.
- Mask and blanking: MASK=10 latched, DOT=01 -> 0. DOT=11 during HB -> R=G=B=0.
- Write bounds: Layers=2, WE with WADDR=5 -> no COL register changes. WE to layer 0 mid-line -> colour changes on the pixel sampled the next cycle.

Source files
------------

// File: rtl/video_mixer_if.sv
// video_mixer_if: timing, layer dots, colour-write bus and pixel/sync outputs.
// master: timing source/controller side; slave: the mixer.
// Ports: HB/VB/HS_/VS_ timing, DOT layer dots, MODE/MASK requests,
//        WE/WADDR/WDATA colour writes, R/G/B pixel, HS_O_/VS_O_ syncs, FRAME.
interface video_mixer_if #(
    parameter int Layers = 2,
    parameter int W      = 4
);
    logic              HB;
    logic              VB;
    logic              HS_;
    logic              VS_;
    logic [Layers-1:0] DOT;
    logic [1:0]        MODE;
    logic [Layers-1:0] MASK;
    logic              WE;
    logic [3:0]        WADDR;
    logic [3*W-1:0]    WDATA;
    logic [W-1:0]      R;
    logic [W-1:0]      G;
    logic [W-1:0]      B;
    logic              HS_O_;
    logic              VS_O_;
    logic              FRAME;

    modport master (
        output HB, VB, HS_, VS_, DOT, MODE, MASK, WE, WADDR, WDATA,
        input  R, G, B, HS_O_, VS_O_, FRAME
    );

    modport slave (
        input  HB, VB, HS_, VS_, DOT, MODE, MASK, WE, WADDR, WDATA,
        output R, G, B, HS_O_, VS_O_, FRAME
    );
endinterface

// File: rtl/video_mixer.sv
// video_mixer: layer compositor between VGA timing and DAC pins.
// Ports: CLK pixel clock, RST_ async active-low reset, vif (slave) carrying
//        timing in, layer dots, mode/mask requests, colour writes, RGB/syncs out.
module video_mixer #(
    parameter int Layers   = 2,
    parameter int W        = 4,
    parameter int SrcDelay = 2
) (
    input  logic         CLK,
    input  logic         RST_,
    video_mixer_if.slave vif
);
    localparam int CW = 3 * W;
    localparam int ND = SrcDelay + 2;
    localparam int SW = W + 4;

    typedef struct packed {
        logic hb;
        logic vb;
        logic hs_n;
        logic vs_n;
    } tim_t;

    localparam tim_t TIM_RST = 4'b1111;

    tim_t              tim_q [ND];
    tim_t              tim_d [ND];
    logic [CW-1:0]     col_q [Layers];
    logic [CW-1:0]     col_d [Layers];
    logic              vb_hist_q;
    logic              vb_hist_d;
    logic [1:0]        mode_q;
    logic [1:0]        mode_d;
    logic [Layers-1:0] mask_q;
    logic [Layers-1:0] mask_d;
    logic              frame_q;
    logic              frame_d;
    logic [Layers-1:0] eff_q;
    logic [Layers-1:0] eff_d;
    logic [1:0]        emode_q;
    logic [1:0]        emode_d;
    logic [CW-1:0]     rgb_q;
    logic [CW-1:0]     rgb_d;

    logic [1:0]        cur_mode;
    logic [Layers-1:0] cur_mask;
    logic              vb_rise;
    logic              blank;
    logic [SW-1:0]     sum_r;
    logic [SW-1:0]     sum_g;
    logic [SW-1:0]     sum_b;
    logic [CW-1:0]     pri_c;
    logic [CW-1:0]     or_c;
    logic [CW-1:0]     mix_c;

    function automatic logic [W-1:0] sat(input logic [SW-1:0] s);
        return (s > SW'({W{1'b1}})) ? {W{1'b1}} : s[W-1:0];
    endfunction

    assign vb_rise = vif.VB & ~vb_hist_q;

    // Frame latch, timing delay line and colour registers.
    always_comb begin
        vb_hist_d = vif.VB;
        mode_d    = mode_q;
        mask_d    = mask_q;
        frame_d   = vb_rise;
        if (vb_rise) begin
            mode_d = vif.MODE;
            mask_d = vif.MASK;
        end
        tim_d[0] = {vif.HB, vif.VB, vif.HS_, vif.VS_};
        for (int k = 1; k < ND; k++) begin
            tim_d[k] = tim_q[k-1];
        end
        for (int i = 0; i < Layers; i++) begin
            col_d[i] = col_q[i];
            if (vif.WE && (vif.WADDR == 4'(i))) begin
                col_d[i] = vif.WDATA;
            end
        end
    end

    // The active mode/mask travels with the timing so that a pixel is
    // mixed with the setting that was live when its timing entered.
    if (SrcDelay == 0) begin : g_nodly
        assign cur_mode = mode_q;
        assign cur_mask = mask_q;
    end else begin : g_dly
        logic [1:0]        md_q [SrcDelay];
        logic [1:0]        md_d [SrcDelay];
        logic [Layers-1:0] mk_q [SrcDelay];
        logic [Layers-1:0] mk_d [SrcDelay];

        always_comb begin
            md_d[0] = mode_q;
            mk_d[0] = mask_q;
            for (int k = 1; k < SrcDelay; k++) begin
                md_d[k] = md_q[k-1];
                mk_d[k] = mk_q[k-1];
            end
        end

        always_ff @(posedge CLK or negedge RST_) begin
            if (!RST_) begin
                for (int k = 0; k < SrcDelay; k++) begin
                    md_q[k] <= 2'd0;
                    mk_q[k] <= '1;
                end
            end else begin
                for (int k = 0; k < SrcDelay; k++) begin
                    md_q[k] <= md_d[k];
                    mk_q[k] <= mk_d[k];
                end
            end
        end

        assign cur_mode = md_q[SrcDelay-1];
        assign cur_mask = mk_q[SrcDelay-1];
    end

    // Stage 1: masked dots.
    always_comb begin
        eff_d   = vif.DOT & cur_mask;
        emode_d = cur_mode;
    end

    // Stage 2: combine layers. Walking from the top index down leaves the
    // lowest set layer in pri_c. Sum width W+4 cannot overflow for 16 layers.
    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        pri_c = '0;
        or_c  = '0;
        for (int i = Layers - 1; i >= 0; i--) begin
            if (eff_q[i]) begin
                pri_c = col_q[i];
                or_c  = or_c | col_q[i];
                sum_r = sum_r + SW'(col_q[i][CW-1 -: W]);
                sum_g = sum_g + SW'(col_q[i][2*W-1 -: W]);
                sum_b = sum_b + SW'(col_q[i][W-1:0]);
            end
        end
        case (emode_q)
            2'd1:    mix_c = {sat(sum_r), sat(sum_g), sat(sum_b)};
            2'd2:    mix_c = or_c;
            default: mix_c = pri_c;
        endcase
        blank = tim_q[SrcDelay].hb | tim_q[SrcDelay].vb;
        rgb_d = blank ? '0 : mix_c;
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            for (int k = 0; k < ND; k++) begin
                tim_q[k] <= TIM_RST;
            end
            for (int i = 0; i < Layers; i++) begin
                col_q[i] <= '1;
            end
            vb_hist_q <= 1'b0;
            mode_q    <= 2'd0;
            mask_q    <= '1;
            frame_q   <= 1'b0;
            eff_q     <= '0;
            emode_q   <= 2'd0;
            rgb_q     <= '0;
        end else begin
            for (int k = 0; k < ND; k++) begin
                tim_q[k] <= tim_d[k];
            end
            for (int i = 0; i < Layers; i++) begin
                col_q[i] <= col_d[i];
            end
            vb_hist_q <= vb_hist_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            frame_q   <= frame_d;
            eff_q     <= eff_d;
            emode_q   <= emode_d;
            rgb_q     <= rgb_d;
        end
    end

    assign vif.R     = rgb_q[CW-1 -: W];
    assign vif.G     = rgb_q[2*W-1 -: W];
    assign vif.B     = rgb_q[W-1:0];
    assign vif.HS_O_ = tim_q[ND-1].hs_n;
    assign vif.VS_O_ = tim_q[ND-1].vs_n;
    assign vif.FRAME = frame_q;
endmodule

// File: tb/tb_video_mixer.sv
// tb_video_mixer: directed and random stimulus for video_mixer,
// checked each cycle against a cycle-history reference model.
module tb_video_mixer;
    localparam int LAY = 2;
    localparam int WW  = 4;
    localparam int SD  = 2;
    localparam int HN  = 8192;

    logic CLK = 1'b0;
    logic RST_;

    video_mixer_if #(.Layers(LAY), .W(WW)) vif ();

    video_mixer #(
        .Layers  (LAY),
        .W       (WW),
        .SrcDelay(SD)
    ) dut (
        .CLK (CLK),
        .RST_(RST_),
        .vif (vif)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    logic       hb_h   [HN];
    logic       vb_h   [HN];
    logic       hs_h   [HN];
    logic       vs_h   [HN];
    logic [1:0] dot_h  [HN];
    logic [1:0] mode_h [HN];
    logic [1:0] mask_h [HN];

    logic [1:0]  m_mode;
    logic [1:0]  m_mask;
    logic        m_pvb;
    logic [11:0] m_col [LAY];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_mode = 2'd0;
        m_mask = 2'b11;
        m_pvb  = 1'b0;
        for (int i = 0; i < LAY; i++) m_col[i] = 12'hFFF;
    endtask

    function automatic logic [11:0] mix(input logic [1:0] md,
                                        input logic [1:0] e);
        int r;
        int g;
        int b;
        logic [11:0] o;
        r = 0;
        g = 0;
        b = 0;
        o = 12'h0;
        if (md == 2'd1) begin
            for (int i = 0; i < LAY; i++) begin
                if (e[i]) begin
                    r += int'(m_col[i][11:8]);
                    g += int'(m_col[i][7:4]);
                    b += int'(m_col[i][3:0]);
                end
            end
            if (r > 15) r = 15;
            if (g > 15) g = 15;
            if (b > 15) b = 15;
            return {4'(r), 4'(g), 4'(b)};
        end
        if (md == 2'd2) begin
            for (int i = 0; i < LAY; i++) if (e[i]) o |= m_col[i];
            return o;
        end
        for (int i = 0; i < LAY; i++) if (e[i]) return m_col[i];
        return 12'h0;
    endfunction

    // One clock: record inputs, predict the output after the edge, check it.
    task automatic tick();
        int t;
        logic [11:0] e_rgb;
        logic e_hs;
        logic e_vs;
        logic e_fr;
        hb_h[cyc]   = vif.HB;
        vb_h[cyc]   = vif.VB;
        hs_h[cyc]   = vif.HS_;
        vs_h[cyc]   = vif.VS_;
        dot_h[cyc]  = vif.DOT;
        mode_h[cyc] = m_mode;
        mask_h[cyc] = m_mask;
        t = cyc - SD - 1;
        if (t < base) begin
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            e_rgb = 12'h0;
        end else begin
            e_hs  = hs_h[t];
            e_vs  = vs_h[t];
            e_rgb = (hb_h[t] | vb_h[t]) ? 12'h0 :
                    mix(mode_h[t], dot_h[cyc-1] & mask_h[t]);
        end
        e_fr = vif.VB && !m_pvb;
        if (e_fr) begin
            m_mode = vif.MODE;
            m_mask = vif.MASK;
        end
        m_pvb = vif.VB;
        if (vif.WE && int'(vif.WADDR) < LAY) m_col[int'(vif.WADDR)] = vif.WDATA;
        @(posedge CLK);
        #1;
        chk("hs_o", 32'(vif.HS_O_), 32'(e_hs));
        chk("vs_o", 32'(vif.VS_O_), 32'(e_vs));
        chk("rgb", 32'({vif.R, vif.G, vif.B}), 32'(e_rgb));
        chk("frame", 32'(vif.FRAME), 32'(e_fr));
        cyc++;
    endtask

    task automatic drive(input logic hb, input logic vb, input logic hs,
                         input logic vs, input logic [1:0] dot);
        vif.HB  = hb;
        vif.VB  = vb;
        vif.HS_ = hs;
        vif.VS_ = vs;
        vif.DOT = dot;
        tick();
    endtask

    task automatic vis(input logic [1:0] dot);
        drive(1'b0, 1'b0, 1'b1, 1'b1, dot);
    endtask

    task automatic vrise();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        vif.WE    = 1'b1;
        vif.WADDR = a;
        vif.WDATA = d;
    endtask

    function automatic logic [11:0] rgb_now();
        return {vif.R, vif.G, vif.B};
    endfunction

    initial begin
        RST_      = 1'b1;
        vif.HB    = 1'b1;
        vif.VB    = 1'b1;
        vif.HS_   = 1'b1;
        vif.VS_   = 1'b1;
        vif.DOT   = '0;
        vif.MODE  = 2'd0;
        vif.MASK  = '1;
        vif.WE    = 1'b0;
        vif.WADDR = 4'd0;
        vif.WDATA = 12'h0;
        reset_model();
        #1 RST_ = 1'b0;
        #1;
        chk("rst_rgb", 32'(rgb_now()), 32'h0);
        chk("rst_hs", 32'(vif.HS_O_), 32'h1);
        chk("rst_vs", 32'(vif.VS_O_), 32'h1);
        chk("rst_frame", 32'(vif.FRAME), 32'h0);

        repeat (2) @(posedge CLK);
        #1 RST_ = 1'b1;
        base = cyc;

        vis(2'b01);
        vis(2'b01);
        vis(2'b01);
        chk("refill_blank", 32'(rgb_now()), 32'h0);
        vis(2'b01);
        chk("first_pix", 32'(rgb_now()), 32'hFFF);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        vis(2'b00);
        vis(2'b01);
        chk("lat_hs_early", 32'(vif.HS_O_), 32'h1);
        vis(2'b00);
        chk("lat_hs", 32'(vif.HS_O_), 32'h0);
        chk("lat_rgb", 32'(rgb_now()), 32'hFFF);

        wr(4'd0, 12'h800);
        vis(2'b00);
        wr(4'd1, 12'h0A0);
        vis(2'b00);
        vif.WE = 1'b0;
        repeat (4) vis(2'b11);
        chk("prio", 32'(rgb_now()), 32'h800);

        vif.MODE = 2'd2;
        vrise();
        chk("frame_or", 32'(vif.FRAME), 32'h1);
        repeat (4) vis(2'b11);
        chk("or_mix", 32'(rgb_now()), 32'h8A0);

        vif.MODE = 2'd1;
        wr(4'd1, 12'h9A0);
        vrise();
        vif.WE = 1'b0;
        repeat (4) vis(2'b11);
        chk("add_sat", 32'(rgb_now()), 32'hFA0);

        vif.MODE = 2'd0;
        repeat (4) vis(2'b11);
        chk("mode_hold", 32'(rgb_now()), 32'hFA0);
        chk("no_frame", 32'(vif.FRAME), 32'h0);
        vrise();
        repeat (4) vis(2'b11);
        chk("mode_new", 32'(rgb_now()), 32'h800);

        vif.MASK = 2'b10;
        vrise();
        repeat (4) vis(2'b01);
        chk("mask_off", 32'(rgb_now()), 32'h0);
        repeat (4) vis(2'b11);
        chk("mask_on", 32'(rgb_now()), 32'h9A0);
        repeat (4) drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b11);
        chk("hblank", 32'(rgb_now()), 32'h0);

        wr(4'd5, 12'h000);
        vis(2'b11);
        vif.WE = 1'b0;
        repeat (4) vis(2'b11);
        chk("waddr_oob", 32'(rgb_now()), 32'h9A0);

        wr(4'd1, 12'h123);
        vis(2'b10);
        vif.WE = 1'b0;
        chk("wr_old", 32'(rgb_now()), 32'h9A0);
        vis(2'b10);
        chk("wr_new", 32'(rgb_now()), 32'h123);

        #3 RST_ = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(rgb_now()), 32'h0);
        chk("mid_rst_hs", 32'(vif.HS_O_), 32'h1);
        chk("mid_rst_vs", 32'(vif.VS_O_), 32'h1);
        repeat (3) @(posedge CLK);
        #1 RST_ = 1'b1;
        reset_model();
        base = cyc;

        for (int n = 0; n < 720; n++) begin
            int h;
            int v;
            h = (n + 5) % 12;
            v = ((n + 5) / 12) % 6;
            vif.WE = 1'b0;
            if ($urandom_range(19) == 0) begin
                vif.MODE = 2'($urandom_range(3));
                vif.MASK = 2'($urandom_range(3));
            end
            if ($urandom_range(7) == 0) begin
                wr(4'($urandom_range(5)), 12'($urandom));
            end
            drive(h >= 8, v >= 4, !(h == 9 || h == 10), !(v == 5),
                  2'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
